// File: rtl/systolic_tile_scheduler.sv
// rtl/systolic_tile_scheduler.sv - tiled matmul job sequencer for the 32x32 systolic array
module systolic_tile_scheduler #(
   parameter int K_W    = 12,
   parameter int TILE_W = 8
) (
   input  logic              clock_sink,
   input  logic              reset_sink_reset_n,
   input  logic [7:0]        csr_address,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   input  logic              csr_read,
   output logic [31:0]       csr_readdata,
   output logic [31:0]       st_instr_data,
   output logic              st_instr_valid,
   input  logic              st_instr_ready,
   input  logic              mon_out_valid,
   input  logic              mon_out_ready,
   output logic [TILE_W-1:0] tile_m,
   output logic [TILE_W-1:0] tile_n,
   output logic              busy,
   output logic              irq
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [7:0] A_CTRL   = 8'h00;
   localparam logic [7:0] A_STATUS = 8'h01;
   localparam logic [7:0] A_CFG    = 8'h02;
   localparam logic [7:0] A_PROG   = 8'h03;
   localparam logic [7:0] A_IRQEN  = 8'h04;

   localparam logic [K_W-1:0]    K_ONE = K_W'(1);
   localparam logic [TILE_W-1:0] T_ONE = TILE_W'(1);

   logic [1:0]        state;
   logic [K_W-1:0]    cfg_k;
   logic [K_W-1:0]    beat_cnt;
   logic [TILE_W-1:0] cfg_m;
   logic [TILE_W-1:0] cfg_n;
   logic [15:0]       progress;
   logic              irq_en;
   logic              done_r;
   logic              cfg_err_r;
   logic              aborted_r;
   logic              abort_pending;

   logic       ctrl_wr;
   logic       start_req;
   logic       abort_req;
   logic       cfg_ok;
   logic       start_go;
   logic       start_bad;
   logic       beat;
   logic       tile_end;
   logic       last_tile;
   logic       abort_now;
   logic       job_done;
   logic       job_abort;
   logic [2:0] status_clr;
   logic       unused_wdata;

   // START and ABORT in one write means abort; START alone only acts from IDLE
   assign ctrl_wr    = csr_write && (csr_address == A_CTRL);
   assign abort_req  = ctrl_wr && csr_writedata[1];
   assign start_req  = ctrl_wr && csr_writedata[0] && !csr_writedata[1];
   assign cfg_ok     = (cfg_k != '0) && (cfg_m != '0) && (cfg_n != '0);
   assign start_go   = start_req && (state == S_IDLE) && cfg_ok;
   assign start_bad  = start_req && (state == S_IDLE) && !cfg_ok;

   // Output beats only count while draining a tile
   assign beat       = (state == S_DRAIN) && mon_out_valid && mon_out_ready;
   assign tile_end   = beat && (beat_cnt == cfg_k - K_ONE);
   assign last_tile  = (tile_m == cfg_m - T_ONE) && (tile_n == cfg_n - T_ONE);
   assign abort_now  = abort_pending || abort_req;
   assign job_done   = tile_end && !abort_now && last_tile;
   assign job_abort  = tile_end && abort_now;
   assign status_clr = (csr_write && (csr_address == A_STATUS)) ? csr_writedata[3:1] : 3'b000;
   assign unused_wdata = ^csr_writedata[31:K_W+2*TILE_W];

   assign busy           = (state != S_IDLE);
   assign st_instr_valid = (state == S_ISSUE);
   assign st_instr_data  = st_instr_valid ? 32'({cfg_k, cfg_k}) : 32'd0;
   assign irq            = irq_en && done_r;

   // Job FSM: one instruction per tile, count output beats, walk tiles row-major
   always_ff @(posedge clock_sink or negedge reset_sink_reset_n) begin
      if (!reset_sink_reset_n) begin
         state         <= S_IDLE;
         beat_cnt      <= '0;
         tile_m        <= '0;
         tile_n        <= '0;
         progress      <= '0;
         abort_pending <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_go) begin
                  state    <= S_ISSUE;
                  tile_m   <= '0;
                  tile_n   <= '0;
                  progress <= '0;
               end
            end
            S_ISSUE: begin
               if (st_instr_ready) begin
                  state    <= S_DRAIN;
                  beat_cnt <= '0;
               end
            end
            S_DRAIN: begin
               if (tile_end) begin
                  progress <= progress + 16'd1;
                  if (abort_now || last_tile) begin
                     state <= S_IDLE;
                  end else begin
                     state <= S_ISSUE;
                     if (tile_n == cfg_n - T_ONE) begin
                        tile_n <= '0;
                        tile_m <= tile_m + T_ONE;
                     end else begin
                        tile_n <= tile_n + T_ONE;
                     end
                  end
               end else if (beat) begin
                  beat_cnt <= beat_cnt + K_ONE;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (busy && abort_req)
            abort_pending <= 1'b1;
         if (tile_end && (abort_now || last_tile))
            abort_pending <= 1'b0;
      end
   end

   // Sticky status bits: a hardware set beats a same-cycle software clear
   always_ff @(posedge clock_sink or negedge reset_sink_reset_n) begin
      if (!reset_sink_reset_n) begin
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
         aborted_r <= 1'b0;
      end else begin
         done_r    <= job_done  || (done_r    && !status_clr[0] && !start_go);
         cfg_err_r <= start_bad || (cfg_err_r && !status_clr[1] && !start_go);
         aborted_r <= job_abort || (aborted_r && !status_clr[2] && !start_go);
      end
   end

   // Job configuration is frozen while a job runs
   always_ff @(posedge clock_sink or negedge reset_sink_reset_n) begin
      if (!reset_sink_reset_n) begin
         cfg_k  <= '0;
         cfg_m  <= '0;
         cfg_n  <= '0;
         irq_en <= 1'b0;
      end else begin
         if (csr_write && (csr_address == A_CFG) && !busy) begin
            cfg_k <= csr_writedata[K_W-1:0];
            cfg_m <= csr_writedata[K_W +: TILE_W];
            cfg_n <= csr_writedata[K_W+TILE_W +: TILE_W];
         end
         if (csr_write && (csr_address == A_IRQEN))
            irq_en <= csr_writedata[0];
      end
   end

   // Registered read mux, one cycle of latency
   always_ff @(posedge clock_sink or negedge reset_sink_reset_n) begin
      if (!reset_sink_reset_n) begin
         csr_readdata <= '0;
      end else if (csr_read) begin
         case (csr_address)
            A_STATUS: csr_readdata <= {28'd0, aborted_r, cfg_err_r, done_r, busy};
            A_CFG:    csr_readdata <= 32'({cfg_n, cfg_m, cfg_k});
            A_PROG:   csr_readdata <= {16'd0, progress};
            A_IRQEN:  csr_readdata <= {31'd0, irq_en};
            default:  csr_readdata <= '0;
         endcase
      end else begin
         csr_readdata <= '0;
      end
   end

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb/tb_systolic_tile_scheduler.sv - directed self-checking bench for systolic_tile_scheduler
module tb_systolic_tile_scheduler;

   logic        clock_sink = 1'b0;
   logic        reset_sink_reset_n = 1'b0;
   logic [7:0]  csr_address = '0;
   logic        csr_write = 1'b0;
   logic [31:0] csr_writedata = '0;
   logic        csr_read = 1'b0;
   logic [31:0] csr_readdata;
   logic [31:0] st_instr_data;
   logic        st_instr_valid;
   logic        st_instr_ready = 1'b0;
   logic        mon_out_valid = 1'b0;
   logic        mon_out_ready = 1'b0;
   logic [7:0]  tile_m;
   logic [7:0]  tile_n;
   logic        busy;
   logic        irq;

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      logic [11:0] k;
      logic [7:0]  m;
      logic [7:0]  n;
      logic        irq_en;
      logic [31:0] exp_data;
      int          exp_instrs;
      int          exp_cycles;
      logic [31:0] exp_prog;
      logic [31:0] exp_status;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[6];

   systolic_tile_scheduler dut (
      .clock_sink         (clock_sink),
      .reset_sink_reset_n (reset_sink_reset_n),
      .csr_address        (csr_address),
      .csr_write          (csr_write),
      .csr_writedata      (csr_writedata),
      .csr_read           (csr_read),
      .csr_readdata       (csr_readdata),
      .st_instr_data      (st_instr_data),
      .st_instr_valid     (st_instr_valid),
      .st_instr_ready     (st_instr_ready),
      .mon_out_valid      (mon_out_valid),
      .mon_out_ready      (mon_out_ready),
      .tile_m             (tile_m),
      .tile_n             (tile_n),
      .busy               (busy),
      .irq                (irq)
   );

   always #5 clock_sink = ~clock_sink;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock_sink);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
      csr_address   = a;
      csr_writedata = d;
      csr_write     = 1'b1;
      tick();
      csr_write     = 1'b0;
   endtask

   task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
      csr_address = a;
      csr_read    = 1'b1;
      tick();
      csr_read    = 1'b0;
      d           = csr_readdata;
   endtask

   task automatic run_job(input vec_t v);
      int          n_instr;
      int          busy_cyc;
      logic [31:0] first_data;
      logic [31:0] rd;
      n_instr    = 0;
      busy_cyc   = 0;
      first_data = '0;
      csr_wr(8'h04, {31'd0, v.irq_en});
      csr_wr(8'h02, {4'd0, v.n, v.m, v.k});
      st_instr_ready = 1'b1;
      mon_out_valid  = 1'b1;
      mon_out_ready  = 1'b1;
      csr_wr(8'h00, 32'h1);
      check("valid_after_start", {31'd0, st_instr_valid}, 32'd1);
      while (busy && busy_cyc < 10000) begin
         if (st_instr_valid) begin
            if (n_instr == 0) first_data = st_instr_data;
            check("tile_m", {24'd0, tile_m}, 32'(n_instr / int'(v.n)));
            check("tile_n", {24'd0, tile_n}, 32'(n_instr % int'(v.n)));
            n_instr++;
         end
         busy_cyc++;
         tick();
      end
      check("job_ended", {31'd0, busy}, 32'd0);
      check("instr_data", first_data, v.exp_data);
      check("instr_count", 32'(n_instr), 32'(v.exp_instrs));
      check("busy_cycles", 32'(busy_cyc), 32'(v.exp_cycles));
      check("irq", {31'd0, irq}, {31'd0, v.exp_irq});
      csr_rd(8'h03, rd);
      check("progress", rd, v.exp_prog);
      csr_rd(8'h01, rd);
      check("status", rd, v.exp_status);
   endtask

   initial begin
      logic [31:0] rd;
      int          cnt;

      vecs[0] = '{12'd4,    8'd1, 8'd1, 1'b1, 32'h0000_4004, 1, 5,    32'd1, 32'h2, 1'b1};
      vecs[1] = '{12'd4,    8'd1, 8'd1, 1'b0, 32'h0000_4004, 1, 5,    32'd1, 32'h2, 1'b0};
      vecs[2] = '{12'd2,    8'd2, 8'd3, 1'b1, 32'h0000_2002, 6, 18,   32'd6, 32'h2, 1'b1};
      vecs[3] = '{12'd1,    8'd1, 8'd2, 1'b0, 32'h0000_1001, 2, 4,    32'd2, 32'h2, 1'b0};
      vecs[4] = '{12'd4095, 8'd1, 8'd1, 1'b1, 32'h00FF_FFFF, 1, 4096, 32'd1, 32'h2, 1'b1};
      vecs[5] = '{12'd3,    8'd3, 8'd1, 1'b1, 32'h0000_3003, 3, 12,   32'd3, 32'h2, 1'b1};

      // Reset state
      repeat (2) tick();
      check("rst_valid", {31'd0, st_instr_valid}, 32'd0);
      check("rst_data", st_instr_data, 32'd0);
      check("rst_tiles", {16'd0, tile_m, tile_n}, 32'd0);
      check("rst_busy_irq", {30'd0, busy, irq}, 32'd0);
      check("rst_readdata", csr_readdata, 32'd0);
      reset_sink_reset_n = 1'b1;
      tick();
      csr_rd(8'h01, rd); check("rst_status", rd, 32'd0);
      csr_rd(8'h02, rd); check("rst_cfg", rd, 32'd0);
      csr_rd(8'h03, rd); check("rst_progress", rd, 32'd0);
      csr_rd(8'h04, rd); check("rst_irq_en", rd, 32'd0);

      // Table-driven full jobs
      for (int i = 0; i < 6; i++) run_job(vecs[i]);

      csr_rd(8'h05, rd); check("unmapped_read", rd, 32'd0);
      csr_rd(8'h00, rd); check("ctrl_read", rd, 32'd0);

      // Instruction stall: valid and data held, DRAIN starts after ready rises
      csr_wr(8'h02, {4'd0, 8'd1, 8'd1, 12'd2});
      st_instr_ready = 1'b0;
      csr_wr(8'h00, 32'h1);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'd0, st_instr_valid}, 32'd1);
         check("stall_data", st_instr_data, 32'h0000_2002);
         if (i == 2) csr_wr(8'h02, 32'h0010_1005);
         else tick();
      end
      st_instr_ready = 1'b1;
      tick();
      st_instr_ready = 1'b0;
      check("drain_entry", {30'd0, busy, st_instr_valid}, 32'b10);
      tick();
      check("drain_beat0", {31'd0, busy}, 32'd1);
      tick();
      check("drain_done", {31'd0, busy}, 32'd0);
      csr_rd(8'h02, rd); check("cfg_locked", rd, 32'h0010_1002);
      csr_rd(8'h03, rd); check("stall_progress", rd, 32'd1);

      // Abort during DRAIN of tile 0 of a 1x4 job
      csr_wr(8'h02, {4'd0, 8'd4, 8'd1, 12'd3});
      st_instr_ready = 1'b1;
      mon_out_valid  = 1'b0;
      csr_wr(8'h00, 32'h1);
      tick();
      check("abort_pre", {30'd0, busy, st_instr_valid}, 32'b10);
      csr_wr(8'h00, 32'h2);
      mon_out_valid = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (st_instr_valid) cnt++;
         tick();
      end
      check("abort_no_reissue", 32'(cnt), 32'd0);
      check("abort_idle", {30'd0, busy, irq}, 32'd0);
      csr_rd(8'h01, rd); check("abort_status", rd, 32'h8);
      csr_rd(8'h03, rd); check("abort_progress", rd, 32'd1);
      csr_wr(8'h01, 32'hE);
      csr_rd(8'h01, rd); check("status_w1c", rd, 32'd0);

      // START together with ABORT in IDLE, and ABORT alone in IDLE, do nothing
      csr_wr(8'h02, {4'd0, 8'd1, 8'd1, 12'd2});
      csr_wr(8'h00, 32'h3);
      check("start_abort_ignored", {30'd0, busy, st_instr_valid}, 32'd0);
      csr_wr(8'h00, 32'h2);
      csr_rd(8'h01, rd); check("idle_abort_status", rd, 32'd0);

      // Zero K is a configuration error
      csr_wr(8'h02, 32'h0010_1000);
      csr_wr(8'h00, 32'h1);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (st_instr_valid || busy) cnt++;
         tick();
      end
      check("cfg_err_no_issue", 32'(cnt), 32'd0);
      csr_rd(8'h01, rd); check("cfg_err_status", rd, 32'h4);
      csr_wr(8'h01, 32'h4);
      csr_rd(8'h01, rd); check("cfg_err_cleared", rd, 32'd0);

      // Asynchronous reset in the middle of DRAIN
      csr_wr(8'h04, 32'h1);
      csr_wr(8'h02, {4'd0, 8'd1, 8'd1, 12'd8});
      st_instr_ready = 1'b1;
      mon_out_valid  = 1'b1;
      csr_wr(8'h00, 32'h1);
      repeat (3) tick();
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 reset_sink_reset_n = 1'b0;
      #1;
      check("async_rst_outs", {st_instr_valid, busy, irq, 13'd0, tile_m, tile_n}, 32'd0);
      check("async_rst_data", st_instr_data, 32'd0);
      tick();
      reset_sink_reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (st_instr_valid || busy) cnt++;
         tick();
      end
      check("no_replay", 32'(cnt), 32'd0);
      csr_rd(8'h02, rd); check("post_rst_cfg", rd, 32'd0);
      csr_rd(8'h04, rd); check("post_rst_irq_en", rd, 32'd0);
      run_job(vecs[2]);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
